smc_seq_ctrl: RTL and testbench
===============================

SMC_SEQ_CTRL -- requirements
Module: smc_seq_ctrl

Interface
REQ-001 The module SHALL have parameter N_MOS, default 6, giving the transistor beats per job; legal range 3..15.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The module SHALL have port in_valid, input, 1, meaning a transistor beat is present.
REQ-005 The module SHALL have port in_ready, output, 1, meaning the block accepts a beat this cycle.
REQ-006 The module SHALL have port in_mode, input, 2, the job mode, sampled on the first beat only.
REQ-007 The module SHALL have ports in_w, in_vgs and in_vds, input, 3 each, the per-transistor W, V_GS and V_DS.
REQ-008 The module SHALL have port out_valid, output, 1, meaning the result is valid.
REQ-009 The module SHALL have port out_ready, input, 1, meaning the consumer accepts the result.
REQ-010 The module SHALL have port out_n, output, 10, the job result.
REQ-011 The module SHALL have port busy, output, 1, high whenever a job is partially loaded or in flight.

Function
REQ-012 A beat SHALL be accepted only on a cycle with in_valid=1 and in_ready=1; a job SHALL be exactly N_MOS accepted beats.
REQ-013 The FSM SHALL have states LOAD, FLUSH, SUM and OUT; in_ready SHALL be 1 only in LOAD.
REQ-014 LOAD->FLUSH SHALL occur on the N_MOS-th accepted beat, and FLUSH->SUM and SUM->OUT SHALL each take one cycle.
REQ-015 OUT->LOAD SHALL occur on out_valid=1 and out_ready=1.
REQ-016 out_valid SHALL be 1 exactly in OUT.
REQ-017 out_n SHALL be registered and held stable while out_valid=1 and out_ready=0.
REQ-018 out_valid SHALL rise 3 cycles after the last accepted beat.
REQ-019 Triode SHALL be defined as vgs > vds+1; otherwise the transistor is in saturation.
REQ-020 Evaluator: with mode[0]=1 (ID), triode SHALL give vds*w*(2*vgs-vds-2) and saturation SHALL give w*(vgs-1)^2.
REQ-021 Evaluator: with mode[0]=0 (gm), triode SHALL give 2*w*vds and saturation SHALL give 2*w*(vgs-1).
REQ-022 Evaluator: vgs-1 SHALL wrap modulo 8, and the result SHALL be floor(product/3) in 10 bits.
REQ-023 Each beat's evaluator result SHALL be registered on acceptance and inserted into a 3-entry sorted register list the following cycle; the final insert occurs in FLUSH.
REQ-024 With mode[1]=1 the list SHALL keep the three largest values; with mode[1]=0 it SHALL keep the three smallest.
REQ-025 The list SHALL be initialised on the first beat of each job: to 0 for the largest-keep case and to 10'h3FF for the smallest-keep case.
REQ-026 Let m0>=m1>=m2 be the kept values in descending order; in SUM, out_n SHALL be m0+m1+m2 when mode[0]=0 and 3*m0+4*m1+5*m2 when mode[0]=1, truncated modulo 1024.
REQ-027 Equal values SHALL yield the same out_n regardless of arrival order.
REQ-028 in_mode on beats other than the first of a job SHALL be ignored.
REQ-029 busy SHALL be (state!=LOAD) or (beat count!=0).

Reset
REQ-030 Reset SHALL force state LOAD, beat count 0, out_valid=0, out_n=0, busy=0, in_ready=1 from the next cycle, and a cleared list.
REQ-031 Reset in any state, including mid-load or in OUT, SHALL discard the partial job, and no result SHALL be emitted for it.

Configuration
REQ-032 With SMC_SEQ_JOB_CNT_EN defined, output job_cnt[7:0] SHALL exist, SHALL reset to 0, SHALL increment on each out handshake, and SHALL wrap from 255 to 0.
REQ-033 Without SMC_SEQ_JOB_CNT_EN, the job_cnt port and its counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-034 Package smc_pkg SHALL hold the FSM state enum, the weights 3/4/5, the sentinel 10'h3FF and the 10-bit result width.
REQ-035 The combinational evaluator SHALL be sub-module smc_mos_eval (inputs mode[0], w, vgs, vds; output 10-bit result), instantiated once and shared by all beats.

Verification
REQ-036 Scenario: 6 beats w=1, vgs=3, vds=1 with mode=11 -> out_n=12; with mode=10 -> out_n=0.
REQ-037 Scenario: 6 beats w=1..6, vgs=4, vds=5 -> out_n=12 for mode=00, 30 for mode=10, 66 for mode=01, 174 for mode=11.
REQ-038 Scenario: 6 beats w=7, vgs=0, vds=3 with mode=11 -> out_n=344 (1368 mod 1024).
REQ-039 Scenario: out_ready held 0 for 5 cycles in OUT -> out_valid=1 and out_n stable throughout, in_ready=0; handshake -> in_ready=1 next cycle.
REQ-040 Scenario: 3 beats, then reset for 1 cycle, then the REQ-037 job with mode=11 -> out_n=174, and the partial job produces no output.
REQ-041 Scenario: random in_valid gaps, back-to-back jobs with out_ready=1 -> out_valid exactly 3 cycles after each job's last beat; job_cnt counts jobs when enabled.

Source files
------------

// File: rtl/smc_pkg.sv
// Shared types, constants and the sorted-list insert helper for the SMC sequencer.
package smc_pkg;

  localparam int RES_W = 10;
  localparam logic [RES_W-1:0] SENTINEL = 10'h3FF;

  // ID-mode weights applied to m0/m1/m2 (descending order)
  localparam logic [12:0] WT0 = 13'd3;
  localparam logic [12:0] WT1 = 13'd4;
  localparam logic [12:0] WT2 = 13'd5;

  typedef enum logic [1:0] {LOAD, FLUSH, SUM, OUT} state_t;

  typedef struct packed {
    logic [RES_W-1:0] m0;
    logic [RES_W-1:0] m1;
    logic [RES_W-1:0] m2;
  } res_list_t;

  // List is always kept descending (m0 >= m1 >= m2) in both keep modes
  function automatic res_list_t list_insert(input res_list_t l,
                                            input logic [RES_W-1:0] v,
                                            input logic keep_max);
    res_list_t r;
    r = l;
    if (keep_max) begin
      if (v > l.m0)      r = '{m0: v,    m1: l.m0, m2: l.m1};
      else if (v > l.m1) r = '{m0: l.m0, m1: v,    m2: l.m1};
      else if (v > l.m2) r = '{m0: l.m0, m1: l.m1, m2: v};
    end else begin
      if (v < l.m2)      r = '{m0: l.m1, m1: l.m2, m2: v};
      else if (v < l.m1) r = '{m0: l.m1, m1: v,    m2: l.m2};
      else if (v < l.m0) r = '{m0: v,    m1: l.m1, m2: l.m2};
    end
    return r;
  endfunction

endpackage

// File: rtl/smc_mos_eval.sv
// Combinational per-transistor evaluator: ID or gm in triode/saturation, divided by 3.
module smc_mos_eval
  import smc_pkg::*;
(
  input  logic             mode0_i,
  input  logic [2:0]       w_i,
  input  logic [2:0]       vgs_i,
  input  logic [2:0]       vds_i,
  output logic [RES_W-1:0] res_o
);

  logic        triode;
  logic [2:0]  vgs_m1;
  logic [11:0] w12, g12, d12, o12, prod;

  // vgs-1 wraps in 3 bits; the triode test itself is done without wrap
  always_comb begin
    vgs_m1 = vgs_i - 3'd1;
    w12    = {9'd0, w_i};
    g12    = {9'd0, vgs_i};
    d12    = {9'd0, vds_i};
    o12    = {9'd0, vgs_m1};
    triode = {1'b0, vgs_i} > ({1'b0, vds_i} + 4'd1);
    if (mode0_i)
      prod = triode ? d12 * w12 * ((g12 << 1) - d12 - 12'd2) : w12 * o12 * o12;
    else
      prod = triode ? (w12 * d12) << 1 : (w12 * o12) << 1;
    res_o = RES_W'(prod / 12'd3);
  end

endmodule

// File: rtl/smc_seq_ctrl.sv
// Beat-serial sequencer: evaluates N_MOS transistors, keeps a 3-entry sorted list, emits a weighted sum.
// Optional job counter output enabled by defining SMC_SEQ_JOB_CNT_EN.
module smc_seq_ctrl
  import smc_pkg::*;
#(
  parameter int N_MOS = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [2:0]       in_w,
  input  logic [2:0]       in_vgs,
  input  logic [2:0]       in_vds,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_n,
  output logic             busy
`ifdef SMC_SEQ_JOB_CNT_EN
  ,
  output logic [7:0]       job_cnt
`endif
);

  state_t           state_q;
  logic [3:0]       cnt_q;
  logic [1:0]       mode_q;
  logic [RES_W-1:0] res_q;
  logic             res_vld_q;
  res_list_t        list_q, list_d;
  logic [RES_W-1:0] out_n_q;
  logic             out_valid_q;
  logic             accept, first_beat, eval_mode;
  logic [RES_W-1:0] eval_res;
  logic [12:0]      wsum;
`ifdef SMC_SEQ_JOB_CNT_EN
  logic [7:0]       job_cnt_q;
  assign job_cnt = job_cnt_q;
`endif

  assign in_ready   = (state_q == LOAD);
  assign accept     = in_valid && in_ready;
  assign first_beat = (cnt_q == 4'd0);
  assign eval_mode  = first_beat ? in_mode[0] : mode_q[0];
  assign busy       = (state_q != LOAD) || (cnt_q != 4'd0);
  assign out_valid  = out_valid_q;
  assign out_n      = out_n_q;

  smc_mos_eval u_eval (
    .mode0_i (eval_mode),
    .w_i     (in_w),
    .vgs_i   (in_vgs),
    .vds_i   (in_vds),
    .res_o   (eval_res)
  );

  always_comb begin
    list_d = list_insert(list_q, res_q, mode_q[1]);
    if (mode_q[0])
      wsum = 13'(list_q.m0) * WT0 + 13'(list_q.m1) * WT1 + 13'(list_q.m2) * WT2;
    else
      wsum = 13'(list_q.m0) + 13'(list_q.m1) + 13'(list_q.m2);
  end

  // Each accepted result is inserted one cycle later; the last insert lands in FLUSH
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LOAD;
      cnt_q       <= 4'd0;
      mode_q      <= 2'b00;
      res_q       <= '0;
      res_vld_q   <= 1'b0;
      list_q      <= '0;
      out_n_q     <= '0;
      out_valid_q <= 1'b0;
`ifdef SMC_SEQ_JOB_CNT_EN
      job_cnt_q   <= 8'd0;
`endif
    end else begin
      res_vld_q <= accept;
      if (accept) res_q <= eval_res;
      if (res_vld_q) list_q <= list_d;
      if (accept && first_beat) begin
        mode_q <= in_mode;
        list_q <= in_mode[1] ? '{m0: '0, m1: '0, m2: '0}
                             : '{m0: SENTINEL, m1: SENTINEL, m2: SENTINEL};
      end
      case (state_q)
        LOAD: begin
          if (accept) begin
            if (cnt_q == 4'(N_MOS - 1)) begin
              cnt_q   <= 4'd0;
              state_q <= FLUSH;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
        end
        FLUSH: state_q <= SUM;
        SUM: begin
          out_n_q     <= RES_W'(wsum);
          out_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= LOAD;
`ifdef SMC_SEQ_JOB_CNT_EN
            job_cnt_q   <= job_cnt_q + 8'd1;
`endif
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_smc_seq_ctrl.sv
// Directed table-driven bench for smc_seq_ctrl plus reset/backpressure corner sequences.
module tb_smc_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_mode;
  logic [2:0] in_w, in_vgs, in_vds;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_n;
  logic       busy;
`ifdef SMC_SEQ_JOB_CNT_EN
  logic [7:0] job_cnt;
  int         jobsDone = 0;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]      mode;
    logic [5:0][2:0] w;
    logic [5:0][2:0] vgs;
    logic [5:0][2:0] vds;
    int              expN;
    string           name;
  } vec_t;

  vec_t vecs[11];

  smc_seq_ctrl #(.N_MOS(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_w      (in_w),
    .in_vgs    (in_vgs),
    .in_vds    (in_vds),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_n     (out_n),
    .busy      (busy)
`ifdef SMC_SEQ_JOB_CNT_EN
    ,
    .job_cnt   (job_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Drives nBeats of vector idx; non-first beats carry the inverted mode, which must be ignored
  task automatic applyStimulus(input int idx, input int nBeats, input int maxGap);
    int gap;
    for (int b = 0; b < nBeats; b++) begin
      @(negedge clk);
      in_valid = 1'b0;
      gap = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
      repeat (gap) @(negedge clk);
      in_w     = vecs[idx].w[b];
      in_vgs   = vecs[idx].vgs[b];
      in_vds   = vecs[idx].vds[b];
      in_mode  = (b == 0) ? vecs[idx].mode : ~vecs[idx].mode;
      in_valid = 1'b1;
      checkOutput("in_ready_load", int'(in_ready), 1);
      @(posedge clk);
    end
  endtask

  // Starts right after the last beat's edge; measures latency, then holds and handshakes
  task automatic awaitResult(input int idx, input int hold);
    int lat;
    lat = 0;
    forever begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
      if (out_valid) break;
      if (lat > 20) begin
        checkOutput("result_timeout", lat, 3);
        return;
      end
    end
    checkOutput("latency", lat, 3);
    checkOutput(vecs[idx].name, int'(out_n), vecs[idx].expN);
    checkOutput("in_ready_out", int'(in_ready), 0);
    checkOutput("busy_out", int'(busy), 1);
    if (hold > 0) begin
      out_ready = 1'b0;
      repeat (hold) begin
        @(negedge clk);
        checkOutput("hold_valid", int'(out_valid), 1);
        checkOutput("hold_stable", int'(out_n), vecs[idx].expN);
        checkOutput("hold_in_ready", int'(in_ready), 0);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("post_hs_valid", int'(out_valid), 0);
    checkOutput("post_hs_in_ready", int'(in_ready), 1);
    checkOutput("post_hs_busy", int'(busy), 0);
`ifdef SMC_SEQ_JOB_CNT_EN
    jobsDone++;
    checkOutput("job_cnt", int'(job_cnt), jobsDone % 256);
`endif
  endtask

  initial begin
    vecs[0]  = '{mode: 2'b11, w: {6{3'd1}}, vgs: {6{3'd3}}, vds: {6{3'd1}}, expN: 12,  name: "id_eq_max"};
    vecs[1]  = '{mode: 2'b10, w: {6{3'd1}}, vgs: {6{3'd3}}, vds: {6{3'd1}}, expN: 0,   name: "gm_eq_max"};
    vecs[2]  = '{mode: 2'b00, w: {3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1}, vgs: {6{3'd4}}, vds: {6{3'd5}}, expN: 12,  name: "gm_min"};
    vecs[3]  = '{mode: 2'b10, w: {3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1}, vgs: {6{3'd4}}, vds: {6{3'd5}}, expN: 30,  name: "gm_max"};
    vecs[4]  = '{mode: 2'b01, w: {3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1}, vgs: {6{3'd4}}, vds: {6{3'd5}}, expN: 66,  name: "id_min"};
    vecs[5]  = '{mode: 2'b11, w: {3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1}, vgs: {6{3'd4}}, vds: {6{3'd5}}, expN: 174, name: "id_max"};
    vecs[6]  = '{mode: 2'b11, w: {6{3'd7}}, vgs: {6{3'd0}}, vds: {6{3'd3}}, expN: 344, name: "id_wrap"};
    vecs[7]  = '{mode: 2'b11, w: {3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6}, vgs: {6{3'd4}}, vds: {6{3'd5}}, expN: 174, name: "id_max_rev"};
    vecs[8]  = '{mode: 2'b01, w: {6{3'd2}}, vgs: {3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}, vds: {6{3'd1}}, expN: 17, name: "id_min_mix"};
    vecs[9]  = '{mode: 2'b11, w: {6{3'd2}}, vgs: {3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}, vds: {6{3'd1}}, expN: 65, name: "id_max_mix"};
    vecs[10] = '{mode: 2'b00, w: {6{3'd2}}, vgs: {3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}, vds: {6{3'd1}}, expN: 3,  name: "gm_min_mix"};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_mode   = 2'b00;
    in_w      = 3'd0;
    in_vgs    = 3'd0;
    in_vds    = 3'd0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_out_n", int'(out_n), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_in_ready", int'(in_ready), 1);
`ifdef SMC_SEQ_JOB_CNT_EN
    checkOutput("rst_job_cnt", int'(job_cnt), 0);
`endif

    $display("[TB] table vectors");
    for (int i = 0; i < 11; i++) begin
      applyStimulus(i, 6, 0);
      awaitResult(i, 0);
    end

    $display("[TB] backpressure hold");
    applyStimulus(5, 6, 0);
    awaitResult(5, 5);

    $display("[TB] reset mid-load");
    applyStimulus(4, 3, 0);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("partial_busy", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("partial_rst_busy", int'(busy), 0);
    checkOutput("partial_rst_in_ready", int'(in_ready), 1);
    repeat (4) begin
      @(negedge clk);
      checkOutput("partial_no_output", int'(out_valid), 0);
    end
    applyStimulus(5, 6, 0);
    awaitResult(5, 0);

    $display("[TB] reset in OUT");
    out_ready = 1'b0;
    applyStimulus(0, 6, 0);
    begin
      int waitCnt;
      waitCnt = 0;
      do begin
        @(negedge clk);
        in_valid = 1'b0;
        waitCnt++;
      end while (!out_valid && waitCnt < 20);
      checkOutput("out_state_reached", int'(out_valid), 1);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    checkOutput("out_rst_valid", int'(out_valid), 0);
    checkOutput("out_rst_n", int'(out_n), 0);
    checkOutput("out_rst_busy", int'(busy), 0);
`ifdef SMC_SEQ_JOB_CNT_EN
    checkOutput("out_rst_job_cnt", int'(job_cnt), 0);
    jobsDone = 0;
`endif

    $display("[TB] back-to-back with random gaps");
    for (int i = 2; i < 11; i++) begin
      applyStimulus(i, 6, 2);
      awaitResult(i, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
